// File: rtl/ring_monitor_pkg.sv
// Shared FSM state encodings and error codes for the ring counter monitor.
package ring_monitor_pkg;

    localparam logic [1:0] StSync  = 2'd0;
    localparam logic [1:0] StTrack = 2'd1;
    localparam logic [1:0] StFault = 2'd2;

    localparam logic [1:0] ErrNone      = 2'd0;
    localparam logic [1:0] ErrNotOnehot = 2'd1;
    localparam logic [1:0] ErrBadSucc   = 2'd2;

endpackage

// File: rtl/ring_monitor_if.sv
// Observation bus between a ring counter source and the monitor.
interface ring_monitor_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned LAPW = 8,
    localparam int unsigned IdxW = $clog2(N)
);
    logic            en;
    logic [N-1:0]    q;
    logic [IdxW-1:0] idx;
    logic            locked;
    logic [LAPW-1:0] lap;
    logic            wrap;
    logic            fault;
    logic [1:0]      err_code;

    modport master (
        output en, q,
        input  idx, locked, lap, wrap, fault, err_code
    );

    modport slave (
        input  en, q,
        output idx, locked, lap, wrap, fault, err_code
    );
endinterface

// File: rtl/ring_monitor_onehot_enc.sv
// Combinational one-hot detector and binary encoder.
module onehot_enc #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    q,
    output logic [IdxW-1:0] idx,
    output logic            is_onehot
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i]) idx = idx | IdxW'(i);
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign is_onehot = (q != '0) && ((q & (q - N'(1))) == '0);
endmodule

// File: rtl/ring_monitor.sv
// Tracks a one-hot ring counter: locks on phase, counts laps, flags illegal steps.
module ring_monitor
    import ring_monitor_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned LAPW = 8,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    ring_monitor_if.slave  bus
);
    logic [1:0]      state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [LAPW-1:0] lap_q, lap_d;
    logic            wrap_q, wrap_d;
    logic [1:0]      err_q, err_d;

    logic [IdxW-1:0] enc_idx;
    logic            enc_onehot;
    logic [N-1:0]    succ;

    onehot_enc #(.N(N)) u_enc (
        .q         (bus.q),
        .idx       (enc_idx),
        .is_onehot (enc_onehot)
    );

    assign succ = {prev_q[N-2:0], prev_q[N-1]};

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        lap_d   = lap_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        if (bus.en) begin
            case (state_q)
                StSync: begin
                    if (enc_onehot) begin
                        prev_d  = bus.q;
                        idx_d   = enc_idx;
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    // Not-one-hot is checked first so it wins over a bad successor.
                    if (!enc_onehot) begin
                        state_d = StFault;
                        err_d   = ErrNotOnehot;
                    end else if (bus.q == succ) begin
                        prev_d = bus.q;
                        idx_d  = enc_idx;
                        if (prev_q[N-1]) begin
                            lap_d  = lap_q + LAPW'(1);
                            wrap_d = 1'b1;
                        end
                    end else if (bus.q != prev_q) begin
                        state_d = StFault;
                        err_d   = ErrBadSucc;
                    end
                end
                StFault: ;
                default: state_d = StSync;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSync;
            prev_q  <= '0;
            idx_q   <= '0;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= ErrNone;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            lap_q   <= lap_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.idx      = idx_q;
    assign bus.locked   = (state_q == StTrack);
    assign bus.fault    = (state_q == StFault);
    assign bus.lap      = lap_q;
    assign bus.wrap     = wrap_q;
    assign bus.err_code = err_q;
endmodule

// File: tb/tb_ring_monitor.sv
// Directed self-checking bench for ring_monitor (N=4, LAPW=8).
module tb_ring_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ring_monitor_if #(.N(4), .LAPW(8)) bus ();

    ring_monitor #(.N(4), .LAPW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] qv, input logic env);
        bus.q  = qv;
        bus.en = env;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) cyc(4'b0001, 1'b1);
        n_cmp++; if (bus.idx !== 2'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", bus.idx); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.lap !== 8'd0) begin n_bad++; $display("FAIL rst_lap: got %0d want 0", bus.lap); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL rst_wrap: got %b want 0", bus.wrap); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", bus.err_code); end
        reset = 1'b0;
    endtask

    task automatic test_sync_ignore();
        cyc(4'b0000, 1'b1);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL sync_zero_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL sync_zero_fault: got %b want 0", bus.fault); end
        cyc(4'b0110, 1'b1);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL sync_multi_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL sync_multi_fault: got %b want 0", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL sync_multi_err: got %b want 00", bus.err_code); end
    endtask

    task automatic test_rotate();
        logic [3:0] qs [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] el [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        for (int k = 0; k < 5; k++) begin
            cyc(qs[k], 1'b1);
            n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL rot_locked[%0d]: got %b want 1", k, bus.locked); end
            n_cmp++; if (bus.idx !== ei[k]) begin n_bad++; $display("FAIL rot_idx[%0d]: got %0d want %0d", k, bus.idx, ei[k]); end
            n_cmp++; if (bus.wrap !== ew[k]) begin n_bad++; $display("FAIL rot_wrap[%0d]: got %b want %b", k, bus.wrap, ew[k]); end
            n_cmp++; if (bus.lap !== el[k]) begin n_bad++; $display("FAIL rot_lap[%0d]: got %0d want %0d", k, bus.lap, el[k]); end
        end
        cyc(4'b0001, 1'b1);
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL rot_wrap_single: got %b want 0", bus.wrap); end
        n_cmp++; if (bus.lap !== 8'd1) begin n_bad++; $display("FAIL rot_lap_hold: got %0d want 1", bus.lap); end
    endtask

    task automatic test_stall();
        logic [3:0] junk [5] = '{4'b0000, 4'b1111, 4'b1000, 4'b0110, 4'b0001};
        cyc(4'b0010, 1'b1);
        cyc(4'b0100, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0100, 1'b1);
            n_cmp++; if (bus.idx !== 2'd2) begin n_bad++; $display("FAIL stall_idx[%0d]: got %0d want 2", k, bus.idx); end
            n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL stall_fault[%0d]: got %b want 0", k, bus.fault); end
            n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL stall_wrap[%0d]: got %b want 0", k, bus.wrap); end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(junk[k], 1'b0);
            n_cmp++; if (bus.idx !== 2'd2) begin n_bad++; $display("FAIL en0_idx[%0d]: got %0d want 2", k, bus.idx); end
            n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL en0_fault[%0d]: got %b want 0", k, bus.fault); end
            n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL en0_locked[%0d]: got %b want 1", k, bus.locked); end
            n_cmp++; if (bus.lap !== 8'd1) begin n_bad++; $display("FAIL en0_lap[%0d]: got %0d want 1", k, bus.lap); end
        end
        cyc(4'b1000, 1'b1);
        n_cmp++; if (bus.idx !== 2'd3) begin n_bad++; $display("FAIL resume_idx: got %0d want 3", bus.idx); end
    endtask

    task automatic test_not_onehot();
        do_reset();
        cyc(4'b0001, 1'b1);
        cyc(4'b0010, 1'b1);
        cyc(4'b0100, 1'b1);
        cyc(4'b0110, 1'b1);
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL noh_fault: got %b want 1", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL noh_err: got %b want 01", bus.err_code); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL noh_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.idx !== 2'd2) begin n_bad++; $display("FAIL noh_idx: got %0d want 2", bus.idx); end
        cyc(4'b1000, 1'b1);
        cyc(4'b0001, 1'b1);
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL noh_sticky: got %b want 1", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL noh_err_frozen: got %b want 01", bus.err_code); end
        n_cmp++; if (bus.idx !== 2'd2) begin n_bad++; $display("FAIL noh_idx_hold: got %0d want 2", bus.idx); end
        n_cmp++; if (bus.lap !== 8'd0) begin n_bad++; $display("FAIL noh_lap_hold: got %0d want 0", bus.lap); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL noh_wrap: got %b want 0", bus.wrap); end
    endtask

    task automatic test_bad_succ();
        do_reset();
        cyc(4'b0001, 1'b1);
        cyc(4'b0010, 1'b1);
        cyc(4'b1000, 1'b1);
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL bad_fault: got %b want 1", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b10) begin n_bad++; $display("FAIL bad_err: got %b want 10", bus.err_code); end
        n_cmp++; if (bus.idx !== 2'd1) begin n_bad++; $display("FAIL bad_idx: got %0d want 1", bus.idx); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL bad_locked: got %b want 0", bus.locked); end
        cyc(4'b1100, 1'b1);
        n_cmp++; if (bus.err_code !== 2'b10) begin n_bad++; $display("FAIL bad_err_frozen: got %b want 10", bus.err_code); end
    endtask

    task automatic test_priority();
        do_reset();
        cyc(4'b0001, 1'b1);
        cyc(4'b1100, 1'b1);
        n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL prio_err: got %b want 01", bus.err_code); end
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL prio_fault: got %b want 1", bus.fault); end
    endtask

    task automatic test_lap_rollover();
        do_reset();
        cyc(4'b0001, 1'b1);
        for (int l = 1; l <= 255; l++) begin
            cyc(4'b0010, 1'b1);
            cyc(4'b0100, 1'b1);
            cyc(4'b1000, 1'b1);
            cyc(4'b0001, 1'b1);
        end
        n_cmp++; if (bus.lap !== 8'd255) begin n_bad++; $display("FAIL roll_lap255: got %0d want 255", bus.lap); end
        n_cmp++; if (bus.wrap !== 1'b1) begin n_bad++; $display("FAIL roll_wrap255: got %b want 1", bus.wrap); end
        cyc(4'b0010, 1'b1);
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL roll_wrap_mid: got %b want 0", bus.wrap); end
        cyc(4'b0100, 1'b1);
        cyc(4'b1000, 1'b1);
        cyc(4'b0001, 1'b1);
        n_cmp++; if (bus.lap !== 8'd0) begin n_bad++; $display("FAIL roll_lap0: got %0d want 0", bus.lap); end
        n_cmp++; if (bus.wrap !== 1'b1) begin n_bad++; $display("FAIL roll_wrap0: got %b want 1", bus.wrap); end
        cyc(4'b0010, 1'b0);
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL roll_en0_wrap: got %b want 0", bus.wrap); end
        n_cmp++; if (bus.idx !== 2'd0) begin n_bad++; $display("FAIL roll_en0_idx: got %0d want 0", bus.idx); end
        n_cmp++; if (bus.lap !== 8'd0) begin n_bad++; $display("FAIL roll_en0_lap: got %0d want 0", bus.lap); end
    endtask

    task automatic test_reset_from_fault();
        cyc(4'b1111, 1'b1);
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL rf_fault: got %b want 1", bus.fault); end
        reset = 1'b1;
        cyc(4'b1111, 1'b1);
        reset = 1'b0;
        n_cmp++; if (bus.idx !== 2'd0) begin n_bad++; $display("FAIL rf_idx: got %0d want 0", bus.idx); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rf_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.lap !== 8'd0) begin n_bad++; $display("FAIL rf_lap: got %0d want 0", bus.lap); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL rf_wrap: got %b want 0", bus.wrap); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rf_fault_clr: got %b want 0", bus.fault); end
        n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL rf_err: got %b want 00", bus.err_code); end
        cyc(4'b1111, 1'b1);
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rf_sync_fault: got %b want 0", bus.fault); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rf_sync_locked: got %b want 0", bus.locked); end
        cyc(4'b0001, 1'b1);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL rf_relock: got %b want 1", bus.locked); end
        n_cmp++; if (bus.idx !== 2'd0) begin n_bad++; $display("FAIL rf_relock_idx: got %0d want 0", bus.idx); end
    endtask

    initial begin
        bus.q  = 4'b0000;
        bus.en = 1'b0;
        test_reset();
        test_sync_ignore();
        test_rotate();
        test_stall();
        test_not_onehot();
        test_bad_succ();
        test_priority();
        test_lap_rollover();
        test_reset_from_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ring_monitor.md
RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter N, default 4: ring width in bits; legal range 2..32.
REQ-002 Parameter LAPW, default 8: width of the lap counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  1  sample enable; when low, all state and outputs hold.
REQ-006 q  input  N  one-hot ring counter phase under observation.
REQ-007 idx  output  clog2(N)  binary position of the last accepted one-hot q.
REQ-008 locked  output  1  high while in TRACK.
REQ-009 lap  output  LAPW  count of completed ring revolutions.
REQ-010 wrap  output  1  one-cycle pulse on each lap increment.
REQ-011 fault  output  1  sticky error flag.
REQ-012 err_code  output  2  00 none, 01 not one-hot, 10 bad successor; frozen once fault is set.

Function
REQ-013 The block SHALL register all outputs; response latency is 1 clk from the sampled q.
REQ-014 States SHALL be SYNC, TRACK and FAULT.
REQ-015 A q value is one-hot when exactly one bit is set; zero and multi-bit values are not one-hot.
REQ-016 Legal successor of prev SHALL be rotate-left: {prev[N-2:0], prev[N-1]}.
REQ-017 In SYNC with en=1: a one-hot q SHALL be stored as prev, update idx, and move to TRACK; a non-one-hot q SHALL be ignored (stay in SYNC, no fault).
REQ-018 In TRACK with en=1 and q==prev: this is a stall; no state change, no error.
REQ-019 In TRACK with en=1 and q==legal successor: prev<=q, idx<=index of q.
REQ-020 In TRACK, accepting a successor where prev[N-1]=1 and q[0]=1 is a wrap; lap SHALL increment and wrap SHALL pulse for exactly one cycle.
REQ-021 lap SHALL wrap modulo 2^LAPW (all ones + 1 -> 0), with wrap still pulsing.
REQ-022 In TRACK with en=1 and q not one-hot: go to FAULT, err_code=01.
REQ-023 In TRACK with en=1 and q one-hot, but neither prev nor the legal successor: go to FAULT, err_code=10.
REQ-024 When both error conditions could apply, code 01 SHALL take priority (a non-one-hot q is never checked for succession).
REQ-025 FAULT SHALL be absorbing until reset; in FAULT: fault=1, locked=0, idx and lap hold, wrap=0.
REQ-026 When en=0, wrap SHALL be 0 and no other output changes.
REQ-027 reset SHALL take priority over en and q in the same cycle.

Reset
REQ-028 On reset the block SHALL enter SYNC with idx=0, locked=0, lap=0, wrap=0, fault=0, err_code=00, prev=0.
REQ-029 Reset asserted mid-operation, including in FAULT, SHALL take effect on the next rising edge; tracking restarts from SYNC.

Structure
REQ-030 State encodings (SYNC=0, TRACK=1, FAULT=2) and error codes SHALL be shared defines in defs.v.
REQ-031 One sub-module, onehot_enc (parameter N), SHALL be combinational: inputs q; outputs idx and is_onehot.
REQ-032 The ring_monitor top SHALL own the FSM, prev register, successor check and lap counter.

Verification (N=4, LAPW=8)
REQ-033 Reset 10 cycles, then q rotating 0001->0010->0100->1000->0001 with en=1 -> locked=1 one cycle after first 0001; idx 0,1,2,3,0; lap=1 with a single wrap pulse after 1000->0001.
REQ-034 While locked at q=0100, drive q=0110 -> fault=1, err_code=01, locked=0; later legal q values change nothing.
REQ-035 While locked at q=0010, drive q=1000 -> fault=1, err_code=10; idx stays 1.
REQ-036 Hold q=0100 for 5 cycles, or toggle en low for 5 cycles while q changes arbitrarily -> no fault; idx stays 2; wrap=0.
REQ-037 Run 256 full laps -> lap reads 255, then 0; wrap pulses at the rollover.
REQ-038 Assert reset while in FAULT with q=1111 -> next cycle all outputs at reset values in SYNC; q=1111 does not fault; a subsequent q=0001 locks.
